// File: rtl/prog_loader.sv
// Program loader: fills instruction memory from a length-prefixed, big-endian byte stream
// while holding the CPU in reset. Optional trailing XOR checksum via PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int INSTR_SIZE   = 16,
   parameter int ADDR_SIZE    = 5,
   parameter int PROGRAM_SIZE = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_SIZE-1:0]  mem_addr,
   output logic [INSTR_SIZE-1:0] mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err
);

   localparam int BYTES = INSTR_SIZE / 8;
   localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(BYTES - 1);
   localparam logic [BC_W-1:0]    ONE_B     = BC_W'(1);
   localparam logic [ADDR_SIZE:0] ONE_A     = (ADDR_SIZE+1)'(1);
   localparam logic [7:0]         MAX_LEN   = 8'(PROGRAM_SIZE);

`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
`endif

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_SIZE-1:0]  r_word_addr;
   logic [ADDR_SIZE:0]    r_len;
   logic [BC_W-1:0]       r_byte_cnt;
   logic [INSTR_SIZE-1:0] r_word;
   logic                  w_last_word;
   logic                  w_bad_len;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]            r_csum;
`endif

   // Extra address bit so a full 2**ADDR_SIZE load still terminates.
   assign w_last_word = (({1'b0, r_word_addr} + ONE_A) == r_len);
   assign w_bad_len   = (in_data == 8'd0) || (in_data > MAX_LEN);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      mem_we   = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      cpu_hold = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: if (start) w_next = S_LEN;
         S_LEN: begin
            in_ready = 1'b1;
            if (in_valid) w_next = w_bad_len ? S_ERR : S_DATA;
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (in_valid && (r_byte_cnt == LAST_BYTE)) w_next = S_WRITE;
         end
         S_WRITE: begin
            mem_we = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            w_next = w_last_word ? S_CSUM : S_DATA;
`else
            w_next = w_last_word ? S_DONE : S_DATA;
`endif
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            if (in_valid) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) w_next = S_LEN;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: word assembly, address and byte counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word_addr <= '0;
         r_len       <= '0;
         r_byte_cnt  <= '0;
         r_word      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         case (r_state)
            S_LEN: if (in_valid) begin
               r_len       <= in_data[ADDR_SIZE:0];
               r_word_addr <= '0;
               r_byte_cnt  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               r_csum      <= in_data;
`endif
            end
            S_DATA: if (in_valid) begin
               r_word     <= (r_word << 8) | INSTR_SIZE'(in_data);
               r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + ONE_B;
`ifdef PROG_LOADER_CHECKSUM_EN
               r_csum     <= r_csum ^ in_data;
`endif
            end
            S_WRITE: r_word_addr <= r_word_addr + 1'b1;
            default: ;
         endcase
      end
   end

   assign mem_addr  = r_word_addr;
   assign mem_wdata = r_word;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: normal loads, length bounds, backpressure,
// mid-load reset, error recovery and (when built with the macro) checksum handling.
module tb_prog_loader;
   logic        clk = 1'b0;
   logic        rst, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, cpu_hold, done, err;
   logic [4:0]  mem_addr;
   logic [15:0] mem_wdata;

   int n_vec = 0, n_miscmp = 0;
   int nwrites = 0, ndone = 0, exp_done = 0;
   logic [15:0] tbmem [0:31];
   logic [15:0] words [0:15];

   prog_loader #(.INSTR_SIZE(16), .ADDR_SIZE(5), .PROGRAM_SIZE(16)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         tbmem[mem_addr] <= mem_wdata;
         nwrites <= nwrites + 1;
      end
      if (done) ndone <= ndone + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bp);
      int k;
      if (bp) begin
         in_valid = 1'b0;
         tick();
      end
      in_valid = 1'b1;
      in_data  = b;
      k = 0;
      while (!in_ready && k < 20) begin
         tick();
         k++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load_body(input int n, input bit bp);
      logic [7:0] x;
      x = n[7:0];
      send_byte(n[7:0], bp);
      for (int w = 0; w < n; w++) begin
         send_byte(words[w][15:8], bp);
         send_byte(words[w][7:0], bp);
         chk("we", mem_we, 1);
         chk("addr", mem_addr, w);
         chk("wdata", mem_wdata, words[w]);
         x = x ^ words[w][15:8] ^ words[w][7:0];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(x, bp);
`else
      tick();
`endif
      chk("done", done, 1);
      chk("hold_at_done", cpu_hold, 1);
      exp_done++;
      tick();
      chk("done_clear", done, 0);
      chk("hold_release", cpu_hold, 0);
   endtask

   task automatic load_words(input int n, input bit bp);
      pulse_start();
      chk("start_ready", in_ready, 1);
      chk("start_hold", cpu_hold, 1);
      chk("start_err_clr", err, 0);
      load_body(n, bp);
   endtask

   initial begin
      int w0;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      tick(); tick();
      chk("rst_ready", in_ready, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      tick();

      // Two-word load: 0x02, 1A05, C003
      words[0] = 16'h1A05; words[1] = 16'hC003;
      load_words(2, 1'b0);
      chk("mem0", tbmem[0], 16'h1A05);
      chk("mem1", tbmem[1], 16'hC003);

      // Length 0 -> error, no write
      w0 = nwrites;
      pulse_start();
      send_byte(8'h00, 1'b0);
      chk("len0_err", err, 1);
      chk("len0_hold", cpu_hold, 1);
      chk("len0_ready", in_ready, 0);
      tick(); tick();
      chk("len0_sticky", err, 1);
      chk("len0_nowrite", nwrites - w0, 0);

      // From ERR: start clears err; length 17 errors again
      pulse_start();
      chk("rec_err_clr", err, 0);
      chk("rec_ready", in_ready, 1);
      send_byte(8'h11, 1'b0);
      chk("len17_err", err, 1);
      chk("len17_nowrite", nwrites - w0, 0);

      // Recovery: one-word load from ERR
      words[0] = 16'hBEEF;
      load_words(1, 1'b0);

      // Maximum length: 16 words
      for (int i = 0; i < 16; i++) words[i] = {8'hA0 + 8'(i), 8'h3C ^ 8'(i)};
      w0 = nwrites;
      load_words(16, 1'b0);
      chk("len16_writes", nwrites - w0, 16);
      chk("mem15", tbmem[15], 16'hAF33);

      // Backpressure: in_valid toggled every other cycle
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'hABCD;
      load_words(3, 1'b1);
      chk("bp_mem2", tbmem[2], 16'hABCD);

      // Reset after 1.5 words
      w0 = nwrites;
      pulse_start();
      send_byte(8'h03, 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'h88, 1'b0);
      chk("mr_we", mem_we, 1);
      chk("mr_wdata", mem_wdata, 16'h7788);
      send_byte(8'h99, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_ready", in_ready, 0);
      chk("mr_we0", mem_we, 0);
      chk("mr_addr", mem_addr, 0);
      chk("mr_wdata0", mem_wdata, 0);
      chk("mr_hold", cpu_hold, 0);
      chk("mr_done", done, 0);
      chk("mr_err", err, 0);
      tick(); tick();
      chk("mr_idle_hold", cpu_hold, 0);
      chk("mr_writes", nwrites - w0, 1);
      chk("mr_mem0", tbmem[0], 16'h7788);
      chk("mr_mem1", tbmem[1], 16'h2222);
      words[0] = 16'h0F0F; words[1] = 16'h5A5A;
      load_words(2, 1'b0);

      // start with in_valid in IDLE: byte 0x00 must not be taken as length
      start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
      tick();
      start = 1'b0; in_valid = 1'b0;
      chk("sv_err", err, 0);
      chk("sv_ready", in_ready, 1);
      words[0] = 16'h4321;
      load_body(1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
      // Good checksum: 01 ^ 12 ^ 34 = 27
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      chk("cs_wdata", mem_wdata, 16'h1234);
      send_byte(8'h27, 1'b0);
      chk("cs_done", done, 1);
      exp_done++;
      tick();
      // Bad checksum
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("csbad_err", err, 1);
      chk("csbad_hold", cpu_hold, 1);
      chk("csbad_done", done, 0);
      tick();
      chk("csbad_sticky", err, 1);
`endif

      tick();
      chk("done_count", ndone, exp_done);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
